// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, flag bit positions and every datapath select value.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_JUMP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_RAM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LESS = 3'b011;

  localparam logic [1:0] FLAGOP_DIS = 2'b00;
  localparam logic [1:0] FLAGOP_SET = 2'b01;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields, ALU flags and memory handshake in,
// per-cycle datapath enables and selects out.
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] NFlag;
  logic        MemReady;

  logic        PCWr;
  logic        IRWr;
  logic        RegWr;
  logic        MemWr;
  logic        MemRd;
  logic        ALUSrc;
  logic [1:0]  RegDst;
  logic [1:0]  Mem2Reg;
  logic [1:0]  NPCSel;
  logic [1:0]  EXTOp;
  logic [2:0]  ALUOp;
  logic [1:0]  FlagOp;
  logic [2:0]  State;
  logic        Illegal;

  modport master (
    input  opcode, funct, NFlag, MemReady,
    output PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, RegDst, Mem2Reg,
           NPCSel, EXTOp, ALUOp, FlagOp, State, Illegal
  );

  modport slave (
    output opcode, funct, NFlag, MemReady,
    input  PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, RegDst, Mem2Reg,
           NPCSel, EXTOp, ALUOp, FlagOp, State, Illegal
  );
endinterface

// File: rtl/multicycle_controller_instr_decode.sv
// Purely combinational opcode/funct classifier; link and jump overlap for jal,
// every other encoding lands in exactly one class.
module instr_decode
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       rtype_alu,
  output logic       imm_alu,
  output logic       load,
  output logic       store,
  output logic       branch,
  output logic       jump,
  output logic       link,
  output logic       jreg,
  output logic       nop,
  output logic       illegal
);

  always_comb begin
    rtype_alu = 1'b0;
    imm_alu   = 1'b0;
    load      = 1'b0;
    store     = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    link      = 1'b0;
    jreg      = 1'b0;
    nop       = 1'b0;
    illegal   = 1'b0;
    if (opcode == OP_RTYPE) begin
      // only a shift of zero is accepted, so funct 0 alone marks the nop
      case (funct)
        FN_ADDU, FN_SUBU, FN_SLT: rtype_alu = 1'b1;
        FN_JR:                    jreg      = 1'b1;
        FN_SLL:                   nop       = 1'b1;
        default:                  illegal   = 1'b1;
      endcase
    end else begin
      case (opcode)
        OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: imm_alu = 1'b1;
        OP_LW:   load   = 1'b1;
        OP_SW:   store  = 1'b1;
        OP_BEQ:  branch = 1'b1;
        OP_J:    jump   = 1'b1;
        OP_JAL: begin
          jump = 1'b1;
          link = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: 2 to 5 cycles per instruction, outputs are Mealy
// on state/IR/flags; FETCH, MEM_RD and MEM_WR stall in place until MemReady.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  state_t     state, state_nxt;
  logic       rtype_alu, imm_alu, load, store, branch, jump, link, jreg, nop, illegal;
  logic       alu_src;
  logic [1:0] ext_op;
  logic [2:0] alu_op;
  logic       unused_flags;

  assign unused_flags = ^bus.NFlag[31:2];

  instr_decode u_decode (
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .rtype_alu (rtype_alu),
    .imm_alu   (imm_alu),
    .load      (load),
    .store     (store),
    .branch    (branch),
    .jump      (jump),
    .link      (link),
    .jreg      (jreg),
    .nop       (nop),
    .illegal   (illegal)
  );

  // ALU setup for the current IR, reused by EXEC and the states that hold it
  always_comb begin
    alu_src = imm_alu | load | store;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    if (rtype_alu) begin
      case (bus.funct)
        FN_SUBU: alu_op = ALU_SUB;
        FN_SLT:  alu_op = ALU_LESS;
        default: alu_op = ALU_ADD;
      endcase
    end else if (bus.opcode == OP_ORI) begin
      alu_op = ALU_OR;
    end else if (bus.opcode == OP_LUI) begin
      ext_op = EXT_LUI;
      alu_op = ALU_OR;
    end else if (imm_alu | load | store) begin
      ext_op = EXT_SIGN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  assign bus.State = state;

  always_comb begin
    state_nxt   = state;
    bus.PCWr    = 1'b0;
    bus.IRWr    = 1'b0;
    bus.RegWr   = 1'b0;
    bus.MemWr   = 1'b0;
    bus.MemRd   = 1'b0;
    bus.ALUSrc  = 1'b0;
    bus.RegDst  = REGDST_RT;
    bus.Mem2Reg = M2R_ALU;
    bus.NPCSel  = NPC_PC4;
    bus.EXTOp   = EXT_ZERO;
    bus.ALUOp   = ALU_ADD;
    bus.FlagOp  = FLAGOP_DIS;
    bus.Illegal = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRd = 1'b1;
        if (bus.MemReady) begin
          bus.IRWr  = 1'b1;
          bus.PCWr  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (nop) begin
          state_nxt = S_FETCH;
        end else if (illegal) begin
          bus.Illegal = 1'b1;
          state_nxt   = S_FETCH;
        end else if (branch) begin
          state_nxt = S_BRANCH;
        end else if (jump | jreg) begin
          state_nxt = S_JUMP;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.ALUSrc = alu_src;
        bus.EXTOp  = ext_op;
        bus.ALUOp  = alu_op;
        if (load)       state_nxt = S_MEM_RD;
        else if (store) state_nxt = S_MEM_WR;
        else            state_nxt = S_WB;
      end
      S_MEM_RD: begin
        bus.MemRd  = 1'b1;
        bus.ALUSrc = alu_src;
        bus.EXTOp  = ext_op;
        bus.ALUOp  = alu_op;
        if (bus.MemReady) state_nxt = S_WB;
      end
      S_MEM_WR: begin
        bus.MemWr = 1'b1;
        if (bus.MemReady) state_nxt = S_FETCH;
      end
      S_WB: begin
        bus.RegWr   = 1'b1;
        bus.ALUSrc  = alu_src;
        bus.EXTOp   = ext_op;
        bus.ALUOp   = alu_op;
        bus.RegDst  = rtype_alu ? REGDST_RD : REGDST_RT;
        bus.Mem2Reg = load ? M2R_RAM : M2R_ALU;
        // only addi traps overflow into the flag register
        if (bus.opcode == OP_ADDI && bus.NFlag[FLAG_OVF]) bus.FlagOp = FLAGOP_SET;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUOp = ALU_SUB;
        if (bus.NFlag[FLAG_ZERO]) begin
          bus.PCWr   = 1'b1;
          bus.NPCSel = NPC_BEQ;
        end
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWr   = 1'b1;
        bus.NPCSel = jreg ? NPC_JR : NPC_J;
        if (link) begin
          bus.RegWr   = 1'b1;
          bus.RegDst  = REGDST_RA;
          bus.Mem2Reg = M2R_PC;
        end
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    if (reset) begin
      bus.PCWr    = 1'b0;
      bus.IRWr    = 1'b0;
      bus.RegWr   = 1'b0;
      bus.MemWr   = 1'b0;
      bus.MemRd   = 1'b0;
      bus.Illegal = 1'b0;
    end
  end

endmodule
